// File: rtl/mpsoc_wb_loader.sv
// Wishbone boot-loader master: optionally zero-fills the tile program memory,
// then writes a stream of program words to consecutive word addresses while
// holding the tile's cores in reset until the image is loaded.
module mpsoc_wb_loader #(
    parameter int unsigned    AW        = 32,
    parameter int unsigned    DW        = 32,
    parameter logic [AW-1:0]  BASE_ADDR = AW'(32'h0000_0000),
    parameter logic [31:0]    MEM_WORDS = 32'h0080_0000,
    parameter int unsigned    TIMEOUT   = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          start_i,
    input  logic          clear_i,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    input  logic          s_last_i,
    output logic          s_ready_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    output logic          cpu_rst_o,
    output logic          done_o,
    output logic          error_o,
    output logic [1:0]    err_code_o,
    output logic [31:0]   words_o
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_BUS  = 2'd1;
    localparam logic [1:0] CODE_TMO  = 2'd2;
    localparam logic [1:0] CODE_OVF  = 2'd3;

    // Byte address of a word index, wrapping at AW bits.
    function automatic logic [AW-1:0] beat_addr(input logic [31:0] idx);
        beat_addr = BASE_ADDR + AW'({idx, 2'b00});
    endfunction

    state_e          state_q, state_d;
    logic [31:0]     idx_q, idx_d;
    logic [31:0]     words_q, words_d;
    logic            cyc_q, cyc_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            last_q, last_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [1:0]      code_q, code_d;
    logic            cpu_rst_q, cpu_rst_d;

    // Next-state logic: beat termination takes priority over everything else
    // because only one beat is ever outstanding.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        words_d   = words_q;
        cyc_d     = cyc_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        done_d    = done_q;
        error_d   = error_q;
        code_d    = code_q;
        cpu_rst_d = cpu_rst_q;

        if (cyc_q) begin
            if (wb_err_i) begin
                // err wins over a simultaneous ack; the word is not counted
                cyc_d     = 1'b0;
                state_d   = ST_ERR;
                error_d   = 1'b1;
                code_d    = CODE_BUS;
                cpu_rst_d = 1'b1;
            end else if (wb_ack_i) begin
                cyc_d = 1'b0;
                case (state_q)
                    ST_CLEAR: begin
                        if (idx_q == (MEM_WORDS - 32'd1)) begin
                            idx_d   = 32'd0;
                            state_d = ST_LOAD;
                        end else begin
                            idx_d = idx_q + 32'd1;
                        end
                    end
                    ST_LOAD: begin
                        words_d = words_q + 32'd1;
                        idx_d   = idx_q + 32'd1;
                        if (last_q) begin
                            state_d   = ST_DONE;
                            done_d    = 1'b1;
                            cpu_rst_d = 1'b0;
                        end else if ((idx_q + 32'd1) == MEM_WORDS) begin
                            // next word would fall outside the memory
                            state_d   = ST_ERR;
                            error_d   = 1'b1;
                            code_d    = CODE_OVF;
                            cpu_rst_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                cyc_d     = 1'b0;
                state_d   = ST_ERR;
                error_d   = 1'b1;
                code_d    = CODE_TMO;
                cpu_rst_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        idx_d     = 32'd0;
                        words_d   = 32'd0;
                        done_d    = 1'b0;
                        error_d   = 1'b0;
                        code_d    = CODE_NONE;
                        cpu_rst_d = 1'b1;
                        state_d   = clear_i ? ST_CLEAR : ST_LOAD;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CLEAR: begin
                    cyc_d = 1'b1;
                    tmo_d = '0;
                    adr_d = beat_addr(idx_q);
                    dat_d = '0;
                end
                ST_LOAD: begin
                    // s_ready_o is high here, so a valid word is a transfer
                    if (s_valid_i) begin
                        cyc_d  = 1'b1;
                        tmo_d  = '0;
                        adr_d  = beat_addr(idx_q);
                        dat_d  = s_data_i;
                        last_d = s_last_i;
                    end else begin
                        cyc_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset drops the bus cycle immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= 32'd0;
            words_q   <= 32'd0;
            cyc_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            last_q    <= 1'b0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= CODE_NONE;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            words_q   <= words_d;
            cyc_q     <= cyc_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            error_q   <= error_d;
            code_q    <= code_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign s_ready_o  = (state_q == ST_LOAD) && !cyc_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = {4{cyc_q}};
    assign wb_we_o    = cyc_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;
    assign cpu_rst_o  = cpu_rst_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = code_q;
    assign words_o    = words_q;

endmodule

// File: tb/tb_mpsoc_wb_loader.sv
// Directed bench for mpsoc_wb_loader with a configurable Wishbone slave model.
module tb_mpsoc_wb_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, clear_i;
    logic [31:0] s_data_i;
    logic        s_valid_i, s_last_i, s_ready_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i;
    logic        cpu_rst_o, done_o, error_o;
    logic [1:0]  err_code_o;
    logic [31:0] words_o;

    int total = 0;
    int bad   = 0;

    // slave configuration (written by the stimulus block only)
    int ws        = 0;
    bit never_ack = 1'b0;
    int err_at    = -1;

    // slave / monitor state (written by the monitor only)
    int          wcnt = 0, beat_cnt = 0, cyc_cnt = 0, log_n = 0;
    int          stab_bad = 0, rdy_bad = 0, acc_n = 0, run_len = 0;
    bit          prev_open = 1'b0;
    logic [31:0] prev_adr, prev_dat;
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    int          log_t   [64];

    always #5 clk = ~clk;

    mpsoc_wb_loader #(
        .AW(32), .DW(32), .BASE_ADDR(32'h0000_1000),
        .MEM_WORDS(32'd8), .TIMEOUT(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .clear_i(clear_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
        .s_ready_o(s_ready_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .cpu_rst_o(cpu_rst_o),
        .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
        .words_o(words_o)
    );

    // Slave responds after ws wait states; optionally raises err with ack.
    assign wb_ack_i = wb_cyc_o && wb_stb_o && !never_ack && (wcnt == ws);
    assign wb_err_i = wb_ack_i && (beat_cnt == err_at);

    // Slave wait counter, write log and protocol monitors.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (wb_cyc_o && wb_stb_o) begin
            wcnt    <= (wb_ack_i || wb_err_i) ? 0 : wcnt + 1;
            run_len <= prev_open ? run_len + 1 : 1;
            if (prev_open && ((wb_adr_o !== prev_adr) || (wb_dat_o !== prev_dat)))
                stab_bad <= stab_bad + 1;
            if (wb_we_o !== 1'b1 || wb_sel_o !== 4'hF)
                stab_bad <= stab_bad + 1;
        end else begin
            wcnt <= 0;
        end
        prev_open <= wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i;
        prev_adr  <= wb_adr_o;
        prev_dat  <= wb_dat_o;
        if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i))
            beat_cnt <= beat_cnt + 1;
        if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && log_n < 64) begin
            log_adr[log_n] <= wb_adr_o;
            log_dat[log_n] <= wb_dat_o;
            log_t[log_n]   <= cyc_cnt;
            log_n          <= log_n + 1;
        end
        if (s_ready_o && wb_cyc_o) rdy_bad <= rdy_bad + 1;
        if (s_valid_i && s_ready_o) acc_n <= acc_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic clr);
        @(negedge clk);
        start_i = 1'b1;
        clear_i = clr;
        @(negedge clk);
        start_i = 1'b0;
        clear_i = 1'b0;
    endtask

    // Offer n words (seed+i), last on the final one; returns words accepted.
    task automatic stream(input int n, input logic [31:0] seed, input bit toggle,
                          input int max_cyc, output int acc);
        int  i  = 0;
        int  c  = 0;
        bit  ph = 1'b0;
        while (i < n && c < max_cyc) begin
            @(negedge clk);
            c++;
            s_valid_i = toggle ? ph : 1'b1;
            ph        = ~ph;
            s_data_i  = seed + 32'(i);
            s_last_i  = (i == n - 1);
            if (s_valid_i && s_ready_o) i++;
        end
        @(negedge clk);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        acc = i;
    endtask

    // Wait (bounded) for the session to end; returns cycle stamp at that point.
    task automatic wait_end(input int bound, output int t);
        int k = 0;
        while (!(done_o || error_o) && k < bound) begin
            @(negedge clk);
            k++;
        end
        t = cyc_cnt;
    endtask

    initial begin
        int b, n, t, rb, sb, ab;
        rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0;
        s_data_i = 32'd0; s_valid_i = 1'b0; s_last_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_rst", cpu_rst_o, 32'd1);
        chk("rst_cyc", wb_cyc_o, 32'd0);
        chk("rst_stb", wb_stb_o, 32'd0);
        chk("rst_we", wb_we_o, 32'd0);
        chk("rst_done", done_o, 32'd0);
        chk("rst_error", error_o, 32'd0);
        chk("rst_words", words_o, 32'd0);
        chk("rst_ready", s_ready_o, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: four words, no clear, zero-wait slave
        b = log_n;
        do_start(1'b0);
        stream(4, 32'hA000_0000, 1'b0, 60, n);
        wait_end(60, t);
        chk("t1_acc", n, 32'd4);
        chk("t1_nwr", log_n - b, 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_adr", log_adr[b+k], 32'h0000_1000 + 32'(4*k));
            chk("t1_dat", log_dat[b+k], 32'hA000_0000 + 32'(k));
        end
        for (int k = 0; k < 3; k++)
            chk("t1_2cyc", log_t[b+k+1] - log_t[b+k], 32'd2);
        chk("t1_done_time", t, log_t[b+3] + 1);
        chk("t1_done", done_o, 32'd1);
        chk("t1_cpu_rst", cpu_rst_o, 32'd0);
        chk("t1_words", words_o, 32'd4);
        chk("t1_error", error_o, 32'd0);
        chk("t1_cti", wb_cti_o, 32'd0);
        chk("t1_bte", wb_bte_o, 32'd0);

        // 2: zero-fill 8 words then 2-word load
        b = log_n;
        do_start(1'b1);
        stream(2, 32'hC000_0000, 1'b0, 100, n);
        wait_end(60, t);
        chk("t2_nwr", log_n - b, 32'd10);
        for (int k = 0; k < 8; k++) begin
            chk("t2_clr_adr", log_adr[b+k], 32'h0000_1000 + 32'(4*k));
            chk("t2_clr_dat", log_dat[b+k], 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            chk("t2_adr", log_adr[b+8+k], 32'h0000_1000 + 32'(4*k));
            chk("t2_dat", log_dat[b+8+k], 32'hC000_0000 + 32'(k));
        end
        chk("t2_words", words_o, 32'd2);
        chk("t2_done", done_o, 32'd1);

        // 3: three wait states, valid toggling
        ws = 3; rb = rdy_bad; sb = stab_bad; ab = acc_n; b = log_n;
        do_start(1'b0);
        stream(4, 32'hB000_0000, 1'b1, 200, n);
        wait_end(100, t);
        chk("t3_acc", n, 32'd4);
        chk("t3_acc_mon", acc_n - ab, 32'd4);
        chk("t3_nwr", log_n - b, 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t3_adr", log_adr[b+k], 32'h0000_1000 + 32'(4*k));
            chk("t3_dat", log_dat[b+k], 32'hB000_0000 + 32'(k));
        end
        chk("t3_stable", stab_bad - sb, 32'd0);
        chk("t3_ready_in_beat", rdy_bad - rb, 32'd0);
        chk("t3_words", words_o, 32'd4);
        chk("t3_done", done_o, 32'd1);
        ws = 0;

        // 4: slave never acks -> timeout after 16 cycles
        never_ack = 1'b1;
        do_start(1'b0);
        stream(1, 32'hD000_0000, 1'b0, 20, n);
        wait_end(60, t);
        chk("t4_error", error_o, 32'd1);
        chk("t4_code", err_code_o, 32'd2);
        chk("t4_cpu_rst", cpu_rst_o, 32'd1);
        chk("t4_cyc", wb_cyc_o, 32'd0);
        chk("t4_stb", wb_stb_o, 32'd0);
        chk("t4_cyc_len", run_len, 32'd16);
        chk("t4_words", words_o, 32'd0);
        chk("t4_done", done_o, 32'd0);
        never_ack = 1'b0;

        // 5: err together with ack on the second word
        err_at = beat_cnt + 1;
        do_start(1'b0);
        stream(3, 32'hE000_0000, 1'b0, 40, n);
        wait_end(20, t);
        chk("t5_error", error_o, 32'd1);
        chk("t5_code", err_code_o, 32'd1);
        chk("t5_words", words_o, 32'd1);
        chk("t5_acc", n, 32'd2);
        chk("t5_cpu_rst", cpu_rst_o, 32'd1);
        err_at = -1;

        // 6: overflow, 9 words into an 8-word memory
        b = log_n;
        do_start(1'b0);
        stream(9, 32'hF000_0000, 1'b0, 80, n);
        wait_end(20, t);
        chk("t6_error", error_o, 32'd1);
        chk("t6_code", err_code_o, 32'd3);
        chk("t6_words", words_o, 32'd8);
        chk("t6_acc", n, 32'd8);
        chk("t6_last_adr", log_adr[b+7], 32'h0000_101C);
        chk("t6_done", done_o, 32'd0);

        // 7: reset mid-beat, then a fresh session
        ws = 10;
        do_start(1'b0);
        stream(1, 32'h1234_5678, 1'b0, 20, n);
        chk("t7_cyc_before", wb_cyc_o, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_cyc_async", wb_cyc_o, 32'd0);
        chk("t7_stb_async", wb_stb_o, 32'd0);
        chk("t7_cpu_rst", cpu_rst_o, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ws = 0;
        @(negedge clk);
        b = log_n;
        do_start(1'b0);
        stream(2, 32'h7700_0000, 1'b0, 40, n);
        wait_end(40, t);
        chk("t7_nwr", log_n - b, 32'd2);
        chk("t7_adr0", log_adr[b], 32'h0000_1000);
        chk("t7_dat1", log_dat[b+1], 32'h7700_0001);
        chk("t7_words", words_o, 32'd2);
        chk("t7_done", done_o, 32'd1);
        chk("t7_cpu_rst_rel", cpu_rst_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
